// File: rtl/sys_rst_seq_pkg.sv
// Shared types and constants for the board-level reset sequencer.
package sys_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    PERIPH_REL = 3'd2,
    RUN        = 3'd3,
    SW_RST     = 3'd4,
    BTN_HOLD   = 3'd5
  } rst_state_e;

  localparam int CausePor      = 0;
  localparam int CauseLockLoss = 1;
  localparam int CauseButton   = 2;
  localparam int CauseDebug    = 3;

  localparam logic [3:0] CauseResetVal = 4'(1 << CausePor);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sys_rst_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
module sys_rst_debounce
  import sys_rst_seq_pkg::*;
#(
  parameter int DebounceCycles = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CntW = $clog2(DebounceCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_level;
  logic [CntW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // The count never passes CntLast, so it cannot wrap.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= CntLast) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/sys_rst_seq.sv
// Reset sequencer: pulses the PLL reset, qualifies lock, then releases
// peripheral and core resets in order and records why it last reset.
module sys_rst_seq
  import sys_rst_seq_pkg::*;
#(
  parameter int PllRstCycles      = 16,
  parameter int LockFilterCycles  = 1024,
  parameter int LockTimeoutCycles = 65536,
  parameter int HoldCycles        = 64,
  parameter int DebounceCycles    = 50000
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_i,
  input  logic       ndmreset_i,
  input  logic       cause_clr_i,
  output logic       pll_reset_o,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       ready_o,
  output logic [3:0] rst_cause_o
);

  localparam int CntW  = $clog2(max3(PllRstCycles, LockTimeoutCycles, HoldCycles)) + 1;
  localparam int FiltW = $clog2(LockFilterCycles) + 1;

  localparam logic [CntW-1:0]  PllLast     = CntW'(PllRstCycles - 1);
  localparam logic [CntW-1:0]  TimeoutLast = CntW'(LockTimeoutCycles - 1);
  localparam logic [CntW-1:0]  HoldLast    = CntW'(HoldCycles - 1);
  localparam logic [FiltW-1:0] FiltLast    = FiltW'(LockFilterCycles - 1);

  rst_state_e       r_state;
  rst_state_e       w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [FiltW-1:0] r_filt;
  logic             r_lock_s1;
  logic             r_lock_s2;
  logic             r_pll_reset;
  logic             r_rst_periph_n;
  logic             r_rst_core_n;
  logic             r_ready;
  logic [3:0]       r_cause;
  logic [3:0]       w_cause_set;
  logic             w_btn;

  sys_rst_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_btn_debounce (
    .i_clk  (clk_sys_i),
    .i_rst  (rst_sys_i),
    .i_raw  (btn_rst_i),
    .o_level(w_btn)
  );

  // NOTE: defaults at the top of the block keep every path assigned, so no latches appear.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_set = '0;
    case (r_state)
      PLL_RST: begin
        if (w_btn) begin
          w_state_nxt              = BTN_HOLD;
          w_cause_set[CauseButton] = 1'b1;
        end else if (r_cnt == PllLast) begin
          w_state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (w_btn) begin
          w_state_nxt              = BTN_HOLD;
          w_cause_set[CauseButton] = 1'b1;
        end else if (r_lock_s2 && (r_filt == FiltLast)) begin
          w_state_nxt = PERIPH_REL;
        end else if (r_cnt == TimeoutLast) begin
          w_state_nxt = PLL_RST;
        end
      end
      PERIPH_REL, RUN, SW_RST: begin
        // Priority: button, then lock loss, then debug request.
        if (w_btn) begin
          w_state_nxt              = BTN_HOLD;
          w_cause_set[CauseButton] = 1'b1;
        end else if (!r_lock_s2) begin
          w_state_nxt                = WAIT_LOCK;
          w_cause_set[CauseLockLoss] = 1'b1;
        end else if (r_state == SW_RST) begin
          if ((r_cnt >= HoldLast) && !ndmreset_i) w_state_nxt = PERIPH_REL;
        end else if (ndmreset_i) begin
          w_state_nxt             = SW_RST;
          w_cause_set[CauseDebug] = 1'b1;
        end else if ((r_state == PERIPH_REL) && (r_cnt == HoldLast)) begin
          w_state_nxt = RUN;
        end
      end
      BTN_HOLD: begin
        if (!w_btn) w_state_nxt = PLL_RST;
      end
      default: w_state_nxt = PLL_RST;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_state        <= PLL_RST;
      r_cnt          <= '0;
      r_filt         <= '0;
      r_lock_s1      <= 1'b0;
      r_lock_s2      <= 1'b0;
      r_pll_reset    <= 1'b1;
      r_rst_periph_n <= 1'b0;
      r_rst_core_n   <= 1'b0;
      r_ready        <= 1'b0;
      r_cause        <= CauseResetVal;
    end else begin
      r_lock_s1 <= pll_locked_i;
      r_lock_s2 <= r_lock_s1;
      r_state   <= w_state_nxt;

      if (w_state_nxt != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)        r_cnt <= r_cnt + 1'b1;

      if ((r_state == WAIT_LOCK) && (w_state_nxt == WAIT_LOCK) && r_lock_s2) begin
        if (r_filt != '1) r_filt <= r_filt + 1'b1;
      end else begin
        r_filt <= '0;
      end

      // Outputs follow the next state so they switch on the same edge as the FSM.
      r_pll_reset    <= (w_state_nxt == PLL_RST) || (w_state_nxt == BTN_HOLD);
      r_rst_periph_n <= (w_state_nxt == PERIPH_REL) || (w_state_nxt == RUN);
      r_rst_core_n   <= (w_state_nxt == RUN);
      r_ready        <= (w_state_nxt == RUN);
      r_cause        <= (cause_clr_i ? 4'b0000 : r_cause) | w_cause_set;
    end
  end

  assign pll_reset_o   = r_pll_reset;
  assign rst_periph_no = r_rst_periph_n;
  assign rst_core_no   = r_rst_core_n;
  assign ready_o       = r_ready;
  assign rst_cause_o   = r_cause;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Directed bench for sys_rst_seq with shortened sequence parameters.
module tb_sys_rst_seq;

  logic       clk;
  logic       rst;
  logic       lock;
  logic       btn;
  logic       ndm;
  logic       clr;
  logic       pll_reset;
  logic       periph_n;
  logic       core_n;
  logic       ready;
  logic [3:0] cause;
  logic [3:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  sys_rst_seq #(
    .PllRstCycles     (4),
    .LockFilterCycles (8),
    .LockTimeoutCycles(32),
    .HoldCycles       (4),
    .DebounceCycles   (3)
  ) dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .pll_locked_i (lock),
    .btn_rst_i    (btn),
    .ndmreset_i   (ndm),
    .cause_clr_i  (clr),
    .pll_reset_o  (pll_reset),
    .rst_periph_no(periph_n),
    .rst_core_no  (core_n),
    .ready_o      (ready),
    .rst_cause_o  (cause)
  );

  // {pll_reset, rst_periph_n, rst_core_n, ready}
  assign outs = {pll_reset, periph_n, core_n, ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; lock = 1'b0; btn = 1'b0; ndm = 1'b0; clr = 1'b0;
    step(2);
    check("reset_outs", outs, 4'b1000);
    check("reset_cause", cause, 4'b0001);

    // Power-up: release reset, lock arrives two cycles later.
    rst = 1'b0;
    step(1);  check("pu_pll_held", outs, 4'b1000);
    step(1);  lock = 1'b1;
    step(1);  check("pu_pll_last", outs, 4'b1000);
    step(1);  check("pu_pll_fall", outs, 4'b0000);
    step(7);  check("pu_filter_wait", outs, 4'b0000);
    step(1);  check("pu_periph_rel", outs, 4'b0100);
    step(3);  check("pu_core_wait", outs, 4'b0100);
    step(1);  check("pu_run", outs, 4'b0111);
    check("pu_cause", cause, 4'b0001);

    // One-cycle lock glitch in RUN.
    lock = 1'b0;
    step(1);  lock = 1'b1;
    step(1);  check("glitch_pending", outs, 4'b0111);
    step(1);  check("glitch_reset", outs, 4'b0000);
    check("glitch_cause", cause, 4'b0011);
    step(7);  check("glitch_filter", outs, 4'b0000);
    step(1);  check("glitch_periph", outs, 4'b0100);
    step(4);  check("glitch_run", outs, 4'b0111);

    // Lock stays low: WAIT_LOCK times out and the PLL reset re-pulses.
    lock = 1'b0;
    step(3);  check("to_enter_wait", outs, 4'b0000);
    step(31); check("to_wait_last", outs, 4'b0000);
    step(1);  check("to_pulse_start", outs, 4'b1000);
    step(3);  check("to_pulse_last", outs, 4'b1000);
    step(1);  check("to_pulse_end", outs, 4'b0000);
    step(31); check("to_wait2_last", outs, 4'b0000);
    step(1);  check("to_pulse2_start", outs, 4'b1000);

    // Relock during the second pulse.
    lock = 1'b1;
    step(4);  check("relock_pll_fall", outs, 4'b0000);
    step(8);  check("relock_periph", outs, 4'b0100);
    step(4);  check("relock_run", outs, 4'b0111);

    // Single-cycle debug reset request.
    ndm = 1'b1;
    step(1);  check("dbg_enter", outs, 4'b0000);
    check("dbg_cause", cause, 4'b1011);
    ndm = 1'b0;
    step(3);  check("dbg_hold_last", outs, 4'b0000);
    step(1);  check("dbg_periph", outs, 4'b0100);
    step(4);  check("dbg_run", outs, 4'b0111);

    // Debug request held for ten cycles.
    ndm = 1'b1;
    step(1);  check("dbg_long_enter", outs, 4'b0000);
    step(9);  check("dbg_long_hold", outs, 4'b0000);
    ndm = 1'b0;
    step(1);  check("dbg_long_periph", outs, 4'b0100);
    step(4);  check("dbg_long_run", outs, 4'b0111);

    // Button bounces 1-0-1 and is then held.
    btn = 1'b1;
    step(1);  btn = 1'b0;
    step(1);  btn = 1'b1;
    step(5);  check("btn_bounce_ignored", outs, 4'b0111);
    step(1);  check("btn_hold", outs, 4'b1000);
    check("btn_cause", cause, 4'b1111);
    btn = 1'b0;
    step(5);  check("btn_hold_release", outs, 4'b1000);
    step(1);  check("btn_pll_rst", outs, 4'b1000);
    step(3);  check("btn_pll_last", outs, 4'b1000);
    step(1);  check("btn_pll_fall", outs, 4'b0000);
    step(8);  check("btn_periph", outs, 4'b0100);
    step(4);  check("btn_run", outs, 4'b0111);

    // Plain clear, then clear coinciding with a lock loss.
    clr = 1'b1;
    step(1);  check("clr_alone", cause, 4'b0000);
    clr = 1'b0; lock = 1'b0;
    step(1);  lock = 1'b1;
    step(1);  clr = 1'b1;
    step(1);  check("clr_vs_lockloss_outs", outs, 4'b0000);
    check("clr_vs_lockloss_cause", cause, 4'b0010);
    clr = 1'b0;
    step(8);  check("pre_rst_periph", outs, 4'b0100);

    // Asynchronous reset in PERIPH_REL.
    rst = 1'b1;
    #1;
    check("async_rst_outs", outs, 4'b1000);
    check("async_rst_cause", cause, 4'b0001);
    step(2);  check("rst_held_outs", outs, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
